// File: rtl/alu_32b.sv
// alu_32b: 32-bit execute-stage ALU with registered result and carry-out.
// Opcode is {S2,S1,S0}. The result is computed combinationally from the
// current operands and captured on every rising clock edge (1-cycle latency).
// Carry-in only affects ADD and SUB. Every other opcode forces carry-out to 0.
module alu_32b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        S0,
    input  logic        S1,
    input  logic        S2,
    input  logic        Ci,
    output logic [31:0] F,
    output logic        Co
);

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_XOR  = 3'b001,
        OP_SUB  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_NOR  = 3'b101,
        OP_SLT  = 3'b110,
        OP_PASS = 3'b111
    } alu_op_e;

    // Signed less-than on two's-complement operands, as a 32-bit result word.
    function automatic logic [31:0] slt_word(input logic [31:0] x, input logic [31:0] y);
        logic lt;
        lt = ($signed(x) < $signed(y)) ? 1'b1 : 1'b0;
        return {31'b0, lt};
    endfunction

    // Run a 33-bit add so that the carry falls out as the top bit.
    function automatic logic [32:0] add33(input logic [31:0] x, input logic [31:0] y,
                                          input logic cin);
        return {1'b0, x} + {1'b0, y} + {32'b0, cin};
    endfunction

    alu_op_e     op_s;
    logic [32:0] sum_s;
    logic [32:0] dif_s;
    logic [31:0] f_d;
    logic        co_d;
    logic [31:0] f_q;
    logic        co_q;

    assign op_s  = alu_op_e'({S2, S1, S0});
    assign sum_s = add33(a, b, Ci);
    // Subtraction is a + ~b + Ci. Carry-out of 1 means no borrow occurred.
    assign dif_s = add33(a, ~b, Ci);

    // Select the next result and carry-out from the current opcode.
    always_comb begin
        f_d  = 32'h0000_0000;
        co_d = 1'b0;
        case (op_s)
            OP_ADD: begin
                f_d  = sum_s[31:0];
                co_d = sum_s[32];
            end
            OP_XOR: begin
                f_d  = a ^ b;
                co_d = 1'b0;
            end
            OP_SUB: begin
                f_d  = dif_s[31:0];
                co_d = dif_s[32];
            end
            OP_AND: begin
                f_d  = a & b;
                co_d = 1'b0;
            end
            OP_OR: begin
                f_d  = a | b;
                co_d = 1'b0;
            end
            OP_NOR: begin
                f_d  = ~(a | b);
                co_d = 1'b0;
            end
            OP_SLT: begin
                f_d  = slt_word(a, b);
                co_d = 1'b0;
            end
            OP_PASS: begin
                f_d  = a;
                co_d = 1'b0;
            end
            default: begin
                // Unknown opcode bits (X/Z) give no defined result and read as zero.
                f_d  = 32'h0000_0000;
                co_d = 1'b0;
            end
        endcase
    end

    // Capture the result each cycle. Async reset clears it and drops any pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_q  <= 32'h0000_0000;
            co_q <= 1'b0;
        end else begin
            f_q  <= f_d;
            co_q <= co_d;
        end
    end

    assign F  = f_q;
    assign Co = co_q;

endmodule

// File: tb/tb_alu_32b.sv
// tb_alu_32b: directed-vector bench for alu_32b with hand-computed expectations.
module tb_alu_32b;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic        S0;
    logic        S1;
    logic        S2;
    logic        Ci;
    logic [31:0] F;
    logic        Co;

    int checks;
    int failures;

    alu_32b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .S0    (S0),
        .S1    (S1),
        .S2    (S2),
        .Ci    (Ci),
        .F     (F),
        .Co    (Co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_f, input logic exp_co);
        checks++;
        assert (F === exp_f && Co === exp_co)
        else begin
            failures++;
            $error("FAIL %s: observed F=%h Co=%b expected F=%h Co=%b", tag, F, Co, exp_f, exp_co);
        end
    endtask

    // Drive one operation between edges, let one rising edge capture it, then check.
    task automatic step(input string tag, input logic [2:0] op, input logic [31:0] va,
                        input logic [31:0] vb, input logic vci,
                        input logic [31:0] exp_f, input logic exp_co);
        @(negedge clk);
        {S2, S1, S0} = op;
        a  = va;
        b  = vb;
        Ci = vci;
        @(posedge clk);
        #1;
        check(tag, exp_f, exp_co);
    endtask

    // Watchdog so that the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        a = 32'h0; b = 32'h0; Ci = 1'b0;
        {S2, S1, S0} = 3'b000;
        #1;
        check("reset_state", 32'h0000_0000, 1'b0);
        // Non-zero inputs under reset must not reach the outputs.
        a = 32'h1234_5678; b = 32'h1111_1111;
        @(posedge clk); #1;
        check("reset_held", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("xor_0", 3'b001, 32'h0101_0101, 32'h6161_6161, 1'b0, 32'h6060_6060, 1'b0);
        step("xor_1", 3'b001, 32'h0101_010F, 32'h6121_6061, 1'b0, 32'h6020_616E, 1'b0);
        step("xor_2", 3'b001, 32'h2501_0107, 32'h6161_6167, 1'b0, 32'h4460_6060, 1'b0);
        step("xor_3", 3'b001, 32'hA501_0107, 32'h6165_6167, 1'b0, 32'hC464_6060, 1'b0);
        step("xor_ci_ignored", 3'b001, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b1, 32'hF0F0_0F0F, 1'b0);
        step("add_wrap", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        step("add_wrap_ci", 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 32'h0000_0001, 1'b1);
        step("add_plain", 3'b000, 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0);
        step("sub_borrow", 3'b010, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0);
        step("sub_noborrow", 3'b010, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1);
        step("sub_zero", 3'b010, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        step("and", 3'b011, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'h00F0_1200, 1'b0);
        step("or", 3'b100, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b1, 32'hFFF0_FF34, 1'b0);
        step("nor", 3'b101, 32'hF0F0_1234, 32'h0FF0_FF00, 1'b0, 32'h000F_00CB, 1'b0);
        step("slt_neg_lt", 3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 1'b0);
        step("slt_pos_ge", 3'b110, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 1'b0);
        step("slt_equal", 3'b110, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b0);
        step("slt_min_max", 3'b110, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 32'h0000_0001, 1'b0);
        step("pass", 3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Mid-operation asynchronous reset, then recovery on the next edge.
        step("pre_reset_add", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 32'h0000_0001, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0000_0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after_release_no_edge", 32'h0000_0000, 1'b0);
        @(posedge clk); #1;
        check("restore_after_reset", 32'h0000_0001, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
